// File: rtl/inst_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int unsigned IF_ADDR_W   = 32;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    // Bits needed to hold a count in the range 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus: pipelined req/gnt request channel with in-order rvalid responses.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = inst_fetch_pkg::IF_ADDR_W,
    parameter int unsigned DATA_W = inst_fetch_pkg::IF_DATA_W
) ();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from the storage array.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = cnt_width(DEPTH),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i && !flush_i));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && empty_o && !flush_i));

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues pipelined bus requests for pc_i, buffers returned
// words with their PCs and presents them to decode; a redirect discards everything older.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W,
    parameter int unsigned DATA_W = IF_DATA_W,
    parameter int unsigned DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              branch_flag_i,
    input  logic [4:0]        stalled,
    inst_fetch_if.master      ibus,
    output logic              fetch_stall_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              if_err_o
);

    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = 1 + DATA_W + ADDR_W;

    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [SUM_W-1:0]   used;
    logic               credit, accept, rsp, drop, push, pop;
    logic [ADDR_W-1:0]  tag_pc;
    logic               tag_empty, tag_full;
    logic [CNT_W-1:0]   tag_cnt;
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty, fifo_full;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               head_err;
    logic               unused_c;

    // Credit covers both in-flight requests and buffered words, so a response always has room.
    assign used   = SUM_W'(outstanding_q) + SUM_W'(fifo_cnt);
    assign credit = used < SUM_W'(DEPTH);

    assign ibus.req      = ce_i & credit & ~branch_flag_i;
    assign ibus.addr     = pc_i;
    assign accept        = ibus.req & ibus.gnt;
    assign fetch_stall_o = ce_i & ~accept & ~branch_flag_i;

    // A response with no request on record (e.g. from before reset) is ignored.
    assign rsp  = ibus.rvalid & ~tag_empty;
    assign drop = rsp & ((drop_cnt_q != '0) | branch_flag_i);
    assign push = rsp & ~drop;
    assign pop  = if_valid_o & ~stalled[1] & ~branch_flag_i;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
        drop_cnt_d    = drop_cnt_q;
        if (branch_flag_i) begin
            drop_cnt_d = outstanding_q - CNT_W'(rsp) + CNT_W'(accept);
        end else if (rsp && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (1'b0),
        .push_i  (accept),
        .pop_i   (rsp),
        .data_i  (pc_i),
        .head_o  (tag_pc),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (tag_cnt)
    );

    fetch_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_data_q (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (branch_flag_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({ibus.err, ibus.rdata, tag_pc}),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    // Faulted words present as NOP; the error flag travels alongside for the trap logic.
    assign head_err   = head[ENTRY_W-1];
    assign if_valid_o = ~fifo_empty;
    assign if_err_o   = if_valid_o & head_err;
    assign if_pc_o    = if_valid_o ? head[ADDR_W-1:0] : '0;
    assign if_inst_o  = (if_valid_o && !head_err) ? head[ADDR_W +: DATA_W] : DATA_W'(NOP_INST);

    assign unused_c = ^{stalled[4:2], stalled[0], tag_full, fifo_full};

    a_outstanding_max: assert property (@(posedge clk) disable iff (!rst)
        outstanding_q <= CNT_W'(DEPTH));
    a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt_q <= outstanding_q);
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rst)
        tag_cnt == outstanding_q);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: bus slave and PC-register models plus an output scoreboard.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          branch_flag_i;
    logic [4:0]    stalled;
    logic          fetch_stall_o;
    logic [AW-1:0] if_pc_o;
    logic [DW-1:0] if_inst_o;
    logic          if_valid_o;
    logic          if_err_o;

    inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) ibus ();

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .branch_flag_i (branch_flag_i),
        .stalled       (stalled),
        .ibus          (ibus),
        .fetch_stall_o (fetch_stall_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o),
        .if_err_o      (if_err_o)
    );

    always #5 clk = ~clk;

    int            n_run = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            lat = 1;
    int            base;
    logic          rsp_hold = 1'b0;
    logic [AW-1:0] err_addr = '1;
    logic [AW-1:0] br_target = '0;
    logic [AW-1:0] sq_addr[$];
    int            sq_due[$];
    logic [95:0]   sb[$];

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [AW-1:0] pc, input logic err);
        sb.push_back({31'b0, err, (err ? NOP_INST : mk_data(pc)), pc});
    endtask

    // One clock: sample at negedge (slave accept capture, scoreboard), then update models after posedge.
    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = ibus.req & ibus.gnt;
        if (acc) begin
            sq_addr.push_back(ibus.addr);
            sq_due.push_back(cyc + lat);
            n_acc++;
        end
        if (if_valid_o && !stalled[1] && !branch_flag_i) begin
            n_run++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed pc %h expected no output", if_pc_o);
            end
            if (sb.size() != 0) chk("sb_word", {31'b0, if_err_o, if_inst_o, if_pc_o}, sb.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
        if (branch_flag_i) pc_i = br_target;
        else if (acc)      pc_i = pc_i + 32'd4;
        branch_flag_i = 1'b0;
        if (!rsp_hold && sq_addr.size() != 0 && sq_due[0] <= cyc) begin
            ibus.rvalid = 1'b1;
            ibus.rdata  = mk_data(sq_addr[0]);
            ibus.err    = (sq_addr[0] == err_addr);
            void'(sq_addr.pop_front());
            void'(sq_due.pop_front());
        end else begin
            ibus.rvalid = 1'b0;
            ibus.rdata  = '0;
            ibus.err    = 1'b0;
        end
    endtask

    task automatic run_until_acc(input int target, input string tag);
        for (int i = 0; i < 40 && n_acc < target; i++) tick();
        chk(tag, 96'(n_acc), 96'(target));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; pc_i = '0; ce_i = 1'b0; branch_flag_i = 1'b0; stalled = '0;
        ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = '0; ibus.err = 1'b0;

        // Reset values
        drain(2);
        chk("rst_req",   96'(ibus.req),   96'(0));
        chk("rst_valid", 96'(if_valid_o), 96'(0));
        chk("rst_err",   96'(if_err_o),   96'(0));
        chk("rst_inst",  96'(if_inst_o),  96'(NOP_INST));
        chk("rst_pc",    96'(if_pc_o),    96'(0));
        rst = 1'b1;

        // Zero-wait slave, 0x0/0x4/0x8
        pc_i = 32'h0; ce_i = 1'b1; ibus.gnt = 1'b1; lat = 1;
        expect_word(32'h0, 1'b0); expect_word(32'h4, 1'b0); expect_word(32'h8, 1'b0);
        base = n_acc;
        #1;
        chk("t1_req",   96'(ibus.req),      96'(1));
        chk("t1_addr",  96'(ibus.addr),     96'(32'h0));
        chk("t1_stall", 96'(fetch_stall_o), 96'(0));
        tick(); #1;
        chk("t1_lat_early", 96'(if_valid_o), 96'(0));
        tick(); #1;
        chk("t1_lat_valid", 96'(if_valid_o), 96'(1));
        chk("t1_lat_pc",    96'(if_pc_o),    96'(32'h0));
        run_until_acc(base + 3, "t1_acc");
        ce_i = 1'b0;
        drain(5);

        // gnt withheld for 3 cycles
        pc_i = 32'h10; ce_i = 1'b1; ibus.gnt = 1'b0;
        expect_word(32'h10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall", 96'(fetch_stall_o), 96'(1));
            chk("t2_req",   96'({ibus.req, ibus.addr}), 96'({1'b1, 32'h10}));
            tick();
        end
        ibus.gnt = 1'b1;
        #1;
        chk("t2_stall_rel", 96'(fetch_stall_o), 96'(0));
        base = n_acc;
        tick();
        ce_i = 1'b0;
        drain(4);
        chk("t2_single", 96'(n_acc), 96'(base + 1));

        // Decode hold with two words buffered
        pc_i = 32'h20; ce_i = 1'b1; stalled = 5'b00010;
        expect_word(32'h20, 1'b0); expect_word(32'h24, 1'b0);
        base = n_acc;
        run_until_acc(base + 2, "t3_acc");
        tick(); #1;
        chk("t3_no_credit", 96'(ibus.req),      96'(0));
        chk("t3_stall",     96'(fetch_stall_o), 96'(1));
        chk("t3_head",      96'({if_valid_o, if_inst_o, if_pc_o}), 96'({1'b1, mk_data(32'h20), 32'h20}));
        tick(); #1;
        chk("t3_head_hold", 96'({if_valid_o, if_inst_o, if_pc_o}), 96'({1'b1, mk_data(32'h20), 32'h20}));
        ce_i = 1'b0; stalled = '0;
        drain(4);

        // Redirect with two requests in flight
        pc_i = 32'h30; ce_i = 1'b1; rsp_hold = 1'b1;
        expect_word(32'h80, 1'b0);
        base = n_acc;
        run_until_acc(base + 2, "t4_acc");
        branch_flag_i = 1'b1; br_target = 32'h80;
        #1;
        chk("t4_br_req",   96'(ibus.req),      96'(0));
        chk("t4_br_stall", 96'(fetch_stall_o), 96'(0));
        tick(); #1;
        chk("t4_flush_valid", 96'(if_valid_o),    96'(0));
        chk("t4_drain_stall", 96'(fetch_stall_o), 96'(1));
        rsp_hold = 1'b0;
        tick(); #1;
        chk("t4_drop_a", 96'(if_valid_o), 96'(0));
        tick(); #1;
        chk("t4_drop_b",   96'(if_valid_o), 96'(0));
        chk("t4_tgt_addr", 96'({ibus.req, ibus.addr}), 96'({1'b1, 32'h80}));
        run_until_acc(base + 3, "t4_acc_tgt");
        ce_i = 1'b0;
        drain(5);

        // Bus error on 0x40
        pc_i = 32'h40; ce_i = 1'b1; err_addr = 32'h40;
        expect_word(32'h40, 1'b1);
        tick();
        ce_i = 1'b0;
        tick(); #1;
        chk("t5_err", 96'({if_valid_o, if_err_o, if_inst_o, if_pc_o}), 96'({1'b1, 1'b1, NOP_INST, 32'h40}));
        drain(3);

        // Reset mid-stream with one buffered and one outstanding
        pc_i = 32'h50; ce_i = 1'b1; stalled = 5'b00010;
        tick();
        rsp_hold = 1'b1;
        tick();
        ce_i = 1'b0;
        #1;
        chk("t6_pre_head", 96'({if_valid_o, if_pc_o}), 96'({1'b1, 32'h50}));
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 96'(if_valid_o), 96'(0));
        chk("t6_rst_out",   96'({ibus.req, if_err_o, if_inst_o, if_pc_o}), 96'({1'b0, 1'b0, NOP_INST, 32'h0}));
        drain(2);
        stalled = '0; rst = 1'b1; rsp_hold = 1'b0;
        drain(3);
        chk("t6_late_valid",  96'(if_valid_o),        96'(0));
        chk("t6_outstanding", 96'(dut.outstanding_q), 96'(0));

        chk("sb_empty", 96'(sb.size()), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and fetch enable, issues pipelined requests on the instruction bus (req/gnt, in-order rvalid), and buffers returned words with their PCs.
- Presents {pc, inst} to the IF/ID boundary.
- Back-pressures the PC register when a request is not accepted.
- Discards in-flight and buffered fetches on a branch redirect.

Parameters:
ADDR_W, 32, instruction address width (matches `InstAddrBus)
DATA_W, 32, instruction word width
DEPTH, 2, max fetches in flight plus buffered (power of 2, >=2)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset (`RstEnable = 0)
pc_i  in  ADDR_W  current fetch PC from PC register
ce_i  in  1  fetch enable from PC register
branch_flag_i  in  1  redirect/flush, same signal driving the PC register
stalled  in  5  pipeline stall vector; stalled[1] = decode stage hold
ibus_req_o  out  1  instruction bus request
ibus_addr_o  out  ADDR_W  request address
ibus_gnt_i  in  1  request accepted this cycle
ibus_rvalid_i  in  1  response valid (in order, >=1 cycle after gnt)
ibus_rdata_i  in  DATA_W  response data
ibus_err_i  in  1  response bus error, qualified by rvalid
fetch_stall_o  out  1  hold request to PC register (ORed into stalled[0] by ctrl)
if_pc_o  out  ADDR_W  PC of presented instruction
if_inst_o  out  DATA_W  presented instruction; NOP 32'h00000013 when not valid
if_valid_o  out  1  presented instruction is valid
if_err_o  out  1  presented instruction fetch faulted

Behaviour:
- Reset (rst low, async): FIFO empty, outstanding=0, drop_cnt=0; ibus_req_o=0, if_valid_o=0, if_err_o=0, if_inst_o=NOP, if_pc_o=0.
- credit = (outstanding + fifo_count) < DEPTH.
- ibus_req_o = ce_i & credit & ~branch_flag_i (combinational); ibus_addr_o = pc_i.
- Slave samples req/addr per cycle. Withdrawing req with no gnt is legal.
- Accept = ibus_req_o & ibus_gnt_i:
  - outstanding +1;
  - pc_i pushed into the address-tag queue (DEPTH entries, in order).
- fetch_stall_o = ce_i & ~accept & ~branch_flag_i. The PC advances only on accepted requests; a redirect is never stalled.
- Response (ibus_rvalid_i):
  - outstanding -1 and tag queue pops.
  - If drop_cnt>0 or branch_flag_i: data is discarded; drop_cnt -1 if >0.
  - Otherwise {tag, rdata, err} is written to the FIFO.
- Latency: gnt in cycle N, rvalid in N+k (k>=1), if_valid_o high from cycle N+k+1. There is no rvalid-to-output bypass.
- Output: if_valid_o = ~fifo_empty. Head drives if_pc_o/if_inst_o/if_err_o.
- Pop when if_valid_o & ~stalled[1] & ~branch_flag_i. When stalled[1]=1, the head holds stable.
- Flush (branch_flag_i=1) takes effect the next cycle:
  - FIFO cleared;
  - drop_cnt <= outstanding - (rvalid this cycle ? 1 : 0) + (accept ? 1 : 0). Accept is 0 by construction.
  - if_valid_o=0 the next cycle.
- A push and a pop in the same cycle with the FIFO full is legal. Credit guarantees no overflow. A push to a full FIFO or a pop from an empty FIFO is a design error (assertion).
- Pointers wrap modulo DEPTH. outstanding and drop_cnt saturate-check against DEPTH (assertion).
- Errors: if_err_o travels with the word. if_inst_o is forced to NOP when err=1. Trap handling belongs downstream.
- Redirect while responses are in flight: all pre-redirect responses are discarded. The first valid output after a redirect carries PC = branch target.

Decomposition:
- yadan_defs.v adds `NopInst (32'h00000013) and `FetchDepth (2). It reuses `InstAddrBus, `RegBus, `RstEnable, `BranchEnable, `NoStop.
- One sub-module: fetch_fifo. It is a synchronous FIFO of DEPTH entries {pc, inst, err} with flush, push, pop, empty, full and count outputs, and an asynchronous active-low reset.
- The tag queue reuses fetch_fifo with inst width 0, or is instantiated as a second fetch_fifo.

Test Plan:
- Zero-wait slave (gnt=1, rvalid 1 cycle later), pc_i 0x0,0x4,0x8 -> if_valid_o from cycle 2; if_pc_o/if_inst_o follow 0x0,0x4,0x8 in order; fetch_stall_o=0 throughout.
- gnt held 0 for 3 cycles with ce_i=1 -> fetch_stall_o=1 for 3 cycles, pc_i held, single request for 0x10 after gnt.
- stalled[1]=1 with 2 words buffered -> ibus_req_o=0 (no credit), head {0x20, data} stable. Releasing the stall pops in order.
- branch_flag_i pulse with 2 requests outstanding, target 0x80 -> both responses discarded, if_valid_o=0. The next output is if_pc_o=0x80.
- ibus_err_i=1 on the response for 0x40 -> if_err_o=1, if_inst_o=32'h00000013, if_pc_o=0x40.
- rst driven low mid-stream with 1 outstanding and 1 buffered -> all outputs return to reset values immediately. A late rvalid after reset release is not written to the FIFO; the bench asserts outstanding=0.
